// File: rtl/uart_pkg.sv
// uart_pkg: shared TX/RX state types and the active-low hex 7-segment decoder
package uart_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  function automatic logic [6:0] seg7_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling deserializer; pulses valid_o only for frames with a good stop bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 10417,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [3:0] data_o
);
  localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int IW = $clog2(BITS_PER_WORD);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_PULSE / 2);
  localparam logic [CW-1:0] HOLD = CW'(CLOCKS_PER_PULSE);
  localparam logic [IW-1:0] TOP  = IW'(BITS_PER_WORD - 1);
  rx_state_e                state_q;
  logic [CW-1:0]            cnt_q;
  logic [IW-1:0]            idx_q;
  logic [BITS_PER_WORD-1:0] sh_q;
  logic                     prev_q;
  logic                     valid_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= rx_i;
      valid_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !rx_i) state_q <= RX_START;
        end
        RX_START: if (cnt_q == HALF) begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= rx_i ? RX_IDLE : RX_DATA;
        end else cnt_q <= cnt_q + 1'b1;
        RX_DATA: if (cnt_q == LAST) begin
          cnt_q <= '0;
          sh_q  <= {rx_i, sh_q[BITS_PER_WORD-1:1]};
          idx_q <= idx_q + 1'b1;
          if (idx_q == TOP) state_q <= RX_STOP;
        end else cnt_q <= cnt_q + 1'b1;
        // HOLD parks the counter after a bad stop bit until the line returns high
        RX_STOP: if (cnt_q == LAST) begin
          valid_q <= rx_i;
          cnt_q   <= rx_i ? '0 : HOLD;
          if (rx_i) state_q <= RX_IDLE;
        end else if (cnt_q == HOLD) begin
          if (rx_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
          end
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= RX_IDLE;
      endcase
    end
  assign valid_o = valid_q;
  assign data_o  = sh_q[3:0];
endmodule

// File: rtl/uart_tx.sv
// uart_tx: start/data(LSB first)/stop serializer with a registered, glitch-free line output
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 10417,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [BITS_PER_WORD-1:0] data_i,
  output logic                     tx_o
);
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int IW = $clog2(BITS_PER_WORD);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [IW-1:0] TOP  = IW'(BITS_PER_WORD - 1);
  tx_state_e              state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [BITS_PER_WORD-1:0] sh_q;
  logic                   tx_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q <= (state_q == TX_IDLE || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      case (state_q)
        TX_IDLE: if (start_i) begin
          state_q <= TX_START;
          sh_q    <= data_i;
          tx_q    <= 1'b0;
        end
        TX_START: if (cnt_q == LAST) begin
          state_q <= TX_DATA;
          idx_q   <= '0;
          tx_q    <= sh_q[0];
          sh_q    <= sh_q >> 1;
        end
        TX_DATA: if (cnt_q == LAST) begin
          if (idx_q == TOP) begin
            state_q <= TX_STOP;
            tx_q    <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
            tx_q  <= sh_q[0];
            sh_q  <= sh_q >> 1;
          end
        end
        TX_STOP: if (cnt_q == LAST) state_q <= TX_IDLE;
        default: state_q <= TX_IDLE;
      endcase
    end
  assign tx_o = tx_q;
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: button-triggered nibble sender plus UART receiver driving a hex 7-segment digit
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 10417,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic       rx,
  output logic       tx,
  output logic [6:0] seg
);
  logic       b1_q, b2_q, b3_q, go_q, r1_q, r2_q, rx_valid;
  logic [3:0] disp_q, rx_data;
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      {b1_q, b2_q, b3_q, go_q} <= '0;
      {r1_q, r2_q}             <= 2'b11;
      disp_q                   <= '0;
    end else begin
      b1_q <= btn;
      b2_q <= b1_q;
      b3_q <= b2_q;
      go_q <= b2_q && !b3_q;
      r1_q <= rx;
      r2_q <= r1_q;
      if (rx_valid) disp_q <= rx_data;
    end
  uart_tx #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE), .BITS_PER_WORD(BITS_PER_WORD)) u_tx (
    .clk    (clk),
    .rst    (rstn),
    .start_i(go_q),
    .data_i (BITS_PER_WORD'(sw)),
    .tx_o   (tx)
  );
  uart_rx #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE), .BITS_PER_WORD(BITS_PER_WORD)) u_rx (
    .clk    (clk),
    .rst    (rstn),
    .rx_i   (r2_q),
    .valid_o(rx_valid),
    .data_o (rx_data)
  );
  assign seg = seg7_decode(disp_q);
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: randomized loopback bench with frame/display scoreboards
module tb_uart_transceiver;
  localparam int CPP = 10, BPW = 8;
  logic clk = 0, rstn = 1, btn = 0, rx_drv = 1, loop = 1;
  logic [3:0] sw = 0;
  logic tx, rx;
  logic [6:0] seg;
  assign rx = loop ? tx : rx_drv;
  uart_transceiver #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW)) dut (
    .clk(clk), .rstn(rstn), .sw(sw), .btn(btn), .rx(rx), .tx(tx), .seg(seg));
  always #5 clk = ~clk;
  int errors = 0, checks = 0, frames = 0, disp = 0;
  logic [BPW+1:0] txq[$];
  logic [6:0] segq[$];
  logic [6:0] seg_prev = 7'b1000000;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [BPW+1:0] frame_of(input int v);
    return {1'b1, BPW'(v), 1'b0};
  endfunction
  task automatic expect_show(input int v);
    if (seg_tab[v] != seg_tab[disp]) segq.push_back(seg_tab[v]);
    disp = v;
  endtask
  task automatic press(input int v, input bit chk);
    int n;
    @(negedge clk);
    sw  = v[3:0];
    btn = 1;
    @(posedge clk);
    #1 btn = 0;
    n = 0;
    if (chk) begin
      while (tx !== 1'b0 && n < 10) begin
        @(posedge clk);
        #1 n++;
      end
      check("start_latency", n, 3);
    end
  endtask
  task automatic send(input int v);
    txq.push_back(frame_of(v));
    expect_show(v);
    press(v, 1);
  endtask
  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((txq.size() != 0 || segq.size() != 0) && n < lim) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL drain: %0d frames and %0d digits still pending, required 0", txq.size(), segq.size());
    end
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [BPW+1:0] bits;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    for (int k = 0; k < BPW + 2; k++) begin
      rx_drv = bits[k];
      repeat (CPP) @(negedge clk);
    end
    rx_drv = 1;
  endtask
  // frame monitor: samples each bit near its middle after seeing the start bit
  always begin : txmon
    logic [BPW+1:0] fr, ex;
    bit ab;
    @(negedge clk);
    if (!rstn && tx === 1'b0) begin
      ab = 0;
      for (int k = 0; k < BPW + 2; k++) begin
        for (int j = 0; j < (k == 0 ? 4 : CPP); j++) begin
          @(negedge clk);
          if (rstn) ab = 1;
        end
        if (ab) break;
        fr[k] = tx;
      end
      if (!ab) begin
        frames++;
        checks++;
        if (txq.size() == 0) begin
          errors++;
          $display("FAIL frame: got unexpected frame %b, required none", fr);
        end else begin
          ex = txq.pop_front();
          if (fr !== ex) begin
            errors++;
            $display("FAIL frame: got %b expected %b", fr, ex);
          end
        end
      end
    end
  end
  always begin : segmon
    logic [6:0] ex;
    @(negedge clk);
    if (rstn) seg_prev = seg;
    else if (seg !== seg_prev) begin
      checks++;
      if (segq.size() == 0) begin
        errors++;
        $display("FAIL seg_change: got %b, required no change from %b", seg, seg_prev);
      end else begin
        ex = segq.pop_front();
        if (seg !== ex) begin
          errors++;
          $display("FAIL seg_change: got %b expected %b", seg, ex);
        end
      end
      seg_prev = seg;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, f0, v;
    bit quiet;
    int seq[4] = '{0, 9, 3, 7};
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_seg", seg, 7'b1000000);
    rstn  = 0;
    quiet = 1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) quiet = 0;
    end
    check("idle_quiet", quiet, 1);
    send(5);
    n = 0;
    while (seg !== 7'b0010010 && n < 107) begin
      @(negedge clk);
      n++;
    end
    check("seg5", seg, 7'b0010010);
    drain(150);
    repeat (10) @(posedge clk);
    foreach (seq[i]) begin
      send(seq[i]);
      drain(150);
      check("seg_seq", seg, seg_tab[seq[i]]);
      repeat (20) @(posedge clk);
    end
    f0 = frames;
    send(4);
    repeat (27) @(posedge clk);
    press(12, 0);
    drain(150);
    repeat (150) @(posedge clk);
    check("one_frame", frames - f0, 1);
    check("busy_press_seg", seg, seg_tab[4]);
    loop = 0;
    rx_frame(8'h0A, 1'b0);
    repeat (30) @(negedge clk);
    check("framing_err_seg", seg, seg_tab[disp]);
    expect_show(10);
    rx_frame(8'h0A, 1'b1);
    drain(50);
    check("rx_valid_seg", seg, 7'b0001000);
    loop = 1;
    repeat (20) @(posedge clk);
    press(6, 0);
    repeat (40) @(negedge clk);
    #2 rstn = 1;
    #1 check("midframe_rst_tx", tx, 1);
    check("midframe_rst_seg", seg, 7'b1000000);
    disp = 0;
    repeat (3) @(negedge clk);
    rstn = 0;
    repeat (5) @(posedge clk);
    send(13);
    drain(150);
    check("post_rst_seg", seg, seg_tab[13]);
    repeat (10) @(posedge clk);
    repeat (6) begin
      v = int'($urandom_range(0, 15));
      send(v);
      drain(150);
      check("rand_seg", seg, seg_tab[v]);
      repeat (10) @(posedge clk);
    end
    check("queues_empty", txq.size() + segq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
